pipeline_run_ctrl: RTL and testbench

Run-control sequencer for the 5-stage MIPS pipeline. It decides on which cycles the PC and the pipeline registers advance. It accepts RUN / STEP / PAUSE / CLEAR commands from the debug host and detects the HALT instruction in ID. On HALT it drains the in-flight instructions through WB before freezing the core. It sits above the hazard unit: its enables are ANDed with the hazard unit's PCWrite / IFIDWrite, and its flush is ORed with the pipeline-register clears.

---
 rtl/pipeline_run_ctrl.sv | 70 +++++++
 tb/tb_pipeline_run_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run/step/pause/clear sequencer that drains the MIPS pipeline on HALT and gates PC and stage enables.
module pipeline_run_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  output logic          cmd_ready,
  input  logic          halt_id,
  output logic          pc_en,
  output logic          pipe_en,
  output logic          ifid_bubble,
  output logic          pipe_flush,
  output logic          step_ack,
  output logic          done,
  output logic [2:0]    state,
  output logic [CW-1:0] cycle_count
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  localparam logic [1:0] CMD_RUN = 2'd0, CMD_STEP = 2'd1, CMD_PAUSE = 2'd2, CMD_CLEAR = 2'd3;

  logic [2:0] nextState;
  logic [DW-1:0] drainCnt;
  logic accept, isClear;

  assign accept = cmd_valid && cmd_ready;
  assign isClear = accept && cmd == CMD_CLEAR;

  // cmd_ready is only high in IDLE/RUN/DONE, so every accepted CLEAR flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      drainCnt    <= '0;
      pipe_flush  <= 1'b0;
      step_ack    <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= nextState;
      drainCnt    <= (nextState == DRAIN && state != DRAIN) ? DW'(DRAIN_CYCLES - 1) :
                     (state == DRAIN && drainCnt != '0) ? drainCnt - DW'(1) : drainCnt;
      pipe_flush  <= isClear;
      step_ack    <= state == STEP && !halt_id;
      cycle_count <= isClear ? '0 :
                     (pipe_en && cycle_count != '1) ? cycle_count + CW'(1) : cycle_count;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = !accept ? IDLE : cmd == CMD_RUN ? RUN : cmd == CMD_STEP ? STEP : IDLE;
      RUN:     nextState = isClear ? IDLE : halt_id ? DRAIN : (accept && cmd == CMD_PAUSE) ? IDLE : RUN;
      STEP:    nextState = halt_id ? DRAIN : IDLE;
      DRAIN:   nextState = drainCnt == '0 ? DONE : DRAIN;
      DONE:    nextState = isClear ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    pipe_en     = state == RUN || state == STEP || state == DRAIN;
    pc_en       = state == RUN || state == STEP;
    ifid_bubble = state == DRAIN;
    done        = state == DONE;
    cmd_ready   = state == IDLE || state == RUN || state == DONE;
  end
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: directed checks of run, step, pause, priority, drain interlock, reset and saturation.
module tb_pipeline_run_ctrl;
  logic clk = 1'b0;
  logic reset, cmd_valid, halt_id;
  logic [1:0] cmd;
  logic cmdReady, pcEn, pipeEn, ifidBubble, pipeFlush, stepAck, done;
  logic [2:0] state;
  logic [31:0] cycleCount;
  logic satReady, satPcEn, satPipeEn, satBubble, satFlush, satAck, satDone;
  logic [2:0] satState;
  logic [3:0] satCount;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.DRAIN_CYCLES(3), .CW(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmdReady),
    .halt_id(halt_id), .pc_en(pcEn), .pipe_en(pipeEn), .ifid_bubble(ifidBubble),
    .pipe_flush(pipeFlush), .step_ack(stepAck), .done(done), .state(state),
    .cycle_count(cycleCount)
  );

  pipeline_run_ctrl #(.DRAIN_CYCLES(3), .CW(4)) sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(satReady),
    .halt_id(halt_id), .pc_en(satPcEn), .pipe_en(satPipeEn), .ifid_bubble(satBubble),
    .pipe_flush(satFlush), .step_ack(satAck), .done(satDone), .state(satState),
    .cycle_count(satCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; halt_id = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc_en", 32'(pcEn), 0);
    chk("rst_pipe_en", 32'(pipeEn), 0);
    chk("rst_bubble", 32'(ifidBubble), 0);
    chk("rst_flush", 32'(pipeFlush), 0);
    chk("rst_step_ack", 32'(stepAck), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", cycleCount, 0);
    chk("rst_ready", 32'(cmdReady), 1);
    // run then halt, with a CLEAR held through the drain
    issue(2'd0);
    chk("run_state", 32'(state), 1);
    chk("run_pipe_en", 32'(pipeEn), 1);
    chk("run_pc_en", 32'(pcEn), 1);
    repeat (7) tick();
    halt_id = 1'b1;
    chk("halt_cycle_count", cycleCount, 7);
    tick();
    halt_id = 1'b0;
    chk("drain1_state", 32'(state), 3);
    chk("drain1_pc_en", 32'(pcEn), 0);
    chk("drain1_pipe_en", 32'(pipeEn), 1);
    chk("drain1_bubble", 32'(ifidBubble), 1);
    cmd_valid = 1'b1; cmd = 2'd3;
    chk("drain1_ready", 32'(cmdReady), 0);
    tick();
    chk("drain2_state", 32'(state), 3);
    tick();
    chk("drain3_state", 32'(state), 3);
    chk("drain3_flush", 32'(pipeFlush), 0);
    tick();
    chk("done_state", 32'(state), 4);
    chk("done_level", 32'(done), 1);
    chk("done_pipe_en", 32'(pipeEn), 0);
    chk("done_count", cycleCount, 11);
    chk("done_flush", 32'(pipeFlush), 0);
    chk("done_ready", 32'(cmdReady), 1);
    tick();
    cmd_valid = 1'b0;
    chk("done_clear_state", 32'(state), 0);
    chk("done_clear_flush", 32'(pipeFlush), 1);
    chk("done_clear_count", cycleCount, 0);
    chk("done_clear_pipe_en", 32'(pipeEn), 0);
    tick();
    chk("flush_one_cycle", 32'(pipeFlush), 0);
    // single step
    issue(2'd1);
    chk("step_state", 32'(state), 2);
    chk("step_pipe_en", 32'(pipeEn), 1);
    chk("step_pc_en", 32'(pcEn), 1);
    chk("step_ready", 32'(cmdReady), 0);
    chk("step_ack_early", 32'(stepAck), 0);
    tick();
    chk("step_back_idle", 32'(state), 0);
    chk("step_ack", 32'(stepAck), 1);
    chk("step_count", cycleCount, 1);
    chk("step_after_pipe_en", 32'(pipeEn), 0);
    tick();
    chk("step_ack_pulse", 32'(stepAck), 0);
    // pause and resume
    issue(2'd3);
    chk("idle_clear_flush", 32'(pipeFlush), 1);
    chk("idle_clear_count", cycleCount, 0);
    issue(2'd0);
    repeat (3) tick();
    chk("pre_pause_count", cycleCount, 3);
    issue(2'd2);
    chk("pause_state", 32'(state), 0);
    chk("pause_pipe_en", 32'(pipeEn), 0);
    chk("pause_count", cycleCount, 4);
    tick(); tick();
    chk("pause_hold_count", cycleCount, 4);
    issue(2'd0);
    chk("resume_state", 32'(state), 1);
    tick();
    chk("resume_count", cycleCount, 5);
    // CLEAR beats halt_id; back-to-back CLEARs flush twice
    cmd_valid = 1'b1; cmd = 2'd3; halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    chk("prio_clear_state", 32'(state), 0);
    chk("prio_clear_flush", 32'(pipeFlush), 1);
    chk("prio_clear_count", cycleCount, 0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_flush", 32'(pipeFlush), 1);
    chk("b2b_state", 32'(state), 0);
    tick();
    chk("b2b_flush_end", 32'(pipeFlush), 0);
    // halt_id beats PAUSE, then reset mid-drain
    issue(2'd0);
    cmd_valid = 1'b1; cmd = 2'd2; halt_id = 1'b1;
    tick();
    cmd_valid = 1'b0; halt_id = 1'b0;
    chk("prio_halt_state", 32'(state), 3);
    tick();
    chk("drain2_before_reset", 32'(state), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_state", 32'(state), 0);
    chk("mid_reset_pipe_en", 32'(pipeEn), 0);
    chk("mid_reset_bubble", 32'(ifidBubble), 0);
    chk("mid_reset_flush", 32'(pipeFlush), 0);
    chk("mid_reset_count", cycleCount, 0);
    chk("mid_reset_ready", 32'(cmdReady), 1);
    repeat (3) tick();
    chk("post_reset_idle", 32'(state), 0);
    chk("post_reset_done", 32'(done), 0);
    // halt during STEP drains without step_ack
    issue(2'd1);
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    chk("step_halt_state", 32'(state), 3);
    chk("step_halt_no_ack", 32'(stepAck), 0);
    repeat (3) tick();
    chk("step_halt_done", 32'(done), 1);
    chk("step_halt_count", cycleCount, 4);
    // saturation on the CW=4 instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(2'd0);
    repeat (20) tick();
    chk("wide_count", cycleCount, 20);
    chk("sat_count", 32'(satCount), 15);
    issue(2'd2);
    chk("final_idle", 32'(state), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
